seg_scan_ctrl: RTL
==================

// Module: seg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for an NDIG-digit common-anode 7-seg display.
//  Shares one hex-to-segment decoder among NDIG digit values plus decimal points.
//  Sits between the counter/datapath registers and the board segment/anode pins.
//  Frame-synchronous shadow registers keep the display free of tearing.
// PARAMETERS
//  NDIG       4      number of digits scanned (2..8)
//  SLOT_CYC   50000  clk cycles per digit slot, blank included
//  BLANK_CYC  16     cycles at slot start with all anodes off (anti-ghosting); BLANK_CYC < SLOT_CYC
//  ACTIVE_LOW 1      1: seg_o, dp_o and an_o are active-low; 0: active-high
// PORTS
//  clk       in   1        clock
//  rst       in   1        reset; asynchronous, active-high
//  enable_i  in   1        1 = scan running, 0 = display dark
//  digits_i  in   4*NDIG   hex nibbles; digit k = digits_i[4k+3:4k], digit 0 rightmost
//  dp_i      in   NDIG     decimal point per digit
//  update_i  in   1        1-cycle strobe: capture digits_i/dp_i for the next frame
//  seg_o     out  7        segments {g,f,e,d,c,b,a}
//  dp_o      out  1        decimal-point segment
//  an_o      out  NDIG     anode enables, one-hot while showing
//  frame_o   out  1        1-cycle pulse when a new frame starts (digit 0 slot)
// BEHAVIOUR
//  - Reset: state IDLE, slot counter 0, digit index 0, shadow regs 0, pending 0.
//    All anodes and segments off at polarity level; frame_o 0.
//  - FSM IDLE: enable_i=1 -> BLANK with idx=0 and frame_o pulse. Otherwise stay.
//  - FSM BLANK: anodes off for BLANK_CYC cycles, then SHOW.
//  - FSM SHOW: an_o[idx] on until the slot counter reaches SLOT_CYC-1.
//    Then idx advances and the FSM goes to BLANK.
//  - idx wraps NDIG-1 -> 0. Each wrap pulses frame_o in the same cycle BLANK(idx 0) is entered.
//  - enable_i=0 in any state: next cycle IDLE, idx 0, outputs dark. No slot completes.
//  - All outputs are registered. seg_o/dp_o/an_o change together, no combinational path from inputs.
//  - Slot counter width $clog2(SLOT_CYC). It resets to 0 on every slot start and every IDLE entry.
//  - update_i sets pending and captures inputs into a staging reg. Latest strobe wins.
//    At frame start, staging -> shadow and pending clears.
//    If update_i coincides with frame start, those inputs go straight to shadow.
//  - Digit shown = shadow nibble[idx]; decode 0-F to standard hex glyphs (b,d lower-case).
//  - Reset mid-frame takes effect immediately (async), regardless of state or pending.
// CONFIGURATION
//  Macro SEG_SCAN_LZB_EN (leading-zero blanking):
//  - Defined: a digit with value 0 and dp 0 is blanked during its SHOW slot (anode off)
//    when every higher-index digit is also blanked. Digit 0 is never blanked. Timing is unchanged.
//  - Undefined: every digit is shown as decoded.
// STRUCTURE
//  - Package seg_scan_pkg: seg7 glyph constant table for 0-F and the FSM state enum
//    (IDLE/BLANK/SHOW).
//  - Sub-module seg7_decoder: combinational nibble -> 7-bit glyph, active-high.
//    Polarity is applied at the output registers.
// TESTING (SLOT_CYC=8, BLANK_CYC=2, NDIG=4, ACTIVE_LOW=1)
//  1. rst then enable_i=1, digits_i=16'h1234, update_i.
//     -> Frame 1 shows old shadow (0000). Frame 2 an_o cycles 1110,1101,1011,0111.
//     -> Slots show seg 4,3,2,1, with each anode low for exactly 6 of 8 cycles.
//  2. Free-run enable -> frame_o pulses every 32 cycles. an_o=1111 during the 2 blank cycles of each slot.
//  3. Three update_i strobes in one frame (16'h1111, 16'h2222, 16'hABCD).
//     -> Next frame shows A,B,C,D glyphs only.
//  4. enable_i dropped mid SHOW of digit 2 -> next cycle an_o=1111, seg_o=7F.
//     -> Re-enable restarts at digit 0 BLANK with a frame_o pulse.
//  5. rst asserted mid SHOW (async) -> outputs dark in the same cycle.
//     -> Pending update discarded, shadow=0.
//  6. SEG_SCAN_LZB_EN, digits 16'h0050, dp_i=0.
//     -> Digits 3,2 anodes stay off. Digit 1 shows 5, digit 0 shows 0. Undefined: all four shown.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seg_scan_ctrl display scanner:
// FSM state encoding and the active-high hex glyph table.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  // Glyphs packed {g,f,e,d,c,b,a}, active-high; b and d are lower-case forms.
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
  };

endpackage

// File: rtl/seg_scan_ctrl_seg7_decoder.sv
// Combinational hex nibble to active-high 7-segment glyph.
module seg7_decoder
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = GLYPH_TABLE[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed NDIG-digit 7-segment scan controller with frame-synchronous shadow registers.
// Optional leading-zero blanking is built when SEG_SCAN_LZB_EN is defined.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int SLOT_CYC   = 50000,
  parameter int BLANK_CYC  = 16,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable_i,
  input  logic [4*NDIG-1:0]   digits_i,
  input  logic [NDIG-1:0]     dp_i,
  input  logic                update_i,
  output logic [6:0]          seg_o,
  output logic                dp_o,
  output logic [NDIG-1:0]     an_o,
  output logic                frame_o
);

  localparam int CNT_W = $clog2(SLOT_CYC);
  localparam int IDX_W = $clog2(NDIG);

  // Off levels double as polarity masks: lit value = active-high value ^ off level.
  localparam logic [6:0]      SEG_OFF = {7{ACTIVE_LOW != 0}};
  localparam logic            DP_OFF  = (ACTIVE_LOW != 0);
  localparam logic [NDIG-1:0] AN_OFF  = {NDIG{ACTIVE_LOW != 0}};

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic [NDIG-1:0][3:0]   stage_dig;
  logic [NDIG-1:0][3:0]   shadow_dig;
  logic [NDIG-1:0]        stage_dp;
  logic [NDIG-1:0]        shadow_dp;
  logic                   pending;
  logic                   slot_end;
  logic                   frame_start;
  logic [6:0]             glyph;
  logic [NDIG-1:0]        lzb;

  assign slot_end    = (state == SHOW) && (cnt == CNT_W'(SLOT_CYC - 1));
  assign frame_start = enable_i &&
                       ((state == IDLE) || (slot_end && (idx == IDX_W'(NDIG - 1))));

  // Staging collects strobes during a frame; shadow only changes at frame start.
  // NOTE: these are plain flops, not a memory array, so they take the async reset like any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_dig  <= '0;
      stage_dp   <= '0;
      shadow_dig <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
    end else if (frame_start) begin
      if (update_i) begin
        shadow_dig <= digits_i;
        shadow_dp  <= dp_i;
      end else if (pending) begin
        shadow_dig <= stage_dig;
        shadow_dp  <= stage_dp;
      end
      pending <= 1'b0;
    end else if (update_i) begin
      stage_dig <= digits_i;
      stage_dp  <= dp_i;
      pending   <= 1'b1;
    end
  end

  seg7_decoder u_dec (
    .nibble (shadow_dig[idx]),
    .glyph  (glyph)
  );

`ifdef SEG_SCAN_LZB_EN
  logic lz_run;

  // A digit blanks only if it and every digit above it are zero with no point.
  always_comb begin
    // NOTE: default every always_comb output first so no path can infer a latch.
    lzb    = '0;
    lz_run = 1'b1;
    for (int k = NDIG - 1; k >= 1; k--) begin
      lzb[k] = lz_run && (shadow_dig[k] == 4'h0) && !shadow_dp[k];
      lz_run = lzb[k];
    end
  end
`else
  assign lzb = '0;
`endif

  // Outputs are loaded on state transitions so seg/dp/an always switch on the same edge.
  // NOTE: all sequential state uses non-blocking assignments to avoid evaluation-order races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      frame_o <= 1'b0;
      seg_o   <= SEG_OFF;
      dp_o    <= DP_OFF;
      an_o    <= AN_OFF;
    end else begin
      frame_o <= frame_start;
      if (!enable_i) begin
        state <= IDLE;
        cnt   <= '0;
        idx   <= '0;
        seg_o <= SEG_OFF;
        dp_o  <= DP_OFF;
        an_o  <= AN_OFF;
      end else begin
        unique case (state)
          IDLE: begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= '0;
          end
          BLANK: begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(BLANK_CYC - 1)) begin
              state <= SHOW;
              if (!lzb[idx]) begin
                seg_o <= glyph ^ SEG_OFF;
                dp_o  <= shadow_dp[idx] ^ DP_OFF;
                an_o  <= (NDIG'(1) << idx) ^ AN_OFF;
              end
            end
          end
          SHOW: begin
            if (slot_end) begin
              state <= BLANK;
              cnt   <= '0;
              idx   <= (idx == IDX_W'(NDIG - 1)) ? '0 : idx + 1'b1;
              seg_o <= SEG_OFF;
              dp_o  <= DP_OFF;
              an_o  <= AN_OFF;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
